// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain: credit-gated read strobes, 2-entry output buffer, valid/ready stream.
// Optional FIFO_DRAIN_CNT_EN adds a 16-bit accepted-beat counter on port word_count.
module fifo_drain_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  localparam int unsigned    BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t           state;
  logic [1:0]       occ;
  logic             inflight;
  logic [BW-1:0]    beat_cnt;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       outstanding;
  logic             pop;

  assign outstanding = occ + {1'b0, inflight};
  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid & out_ready;
  assign out_data    = slot0;
  assign out_last    = out_valid & (beat_cnt == LAST_BEAT);
  assign busy        = inflight | out_valid;

  // A full credit count may still issue a read when the head leaves this cycle.
  always_comb begin
    fifo_read = 1'b0;
    if (reset_n && (state == S_RUN) && !fifo_empty) begin
      fifo_read = (outstanding < 2'd2) | ((outstanding == 2'd2) & pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      slot0    <= '0;
      slot1    <= '0;
    end else begin
      inflight <= fifo_read;

      unique case (state)
        S_IDLE: if (enable) state <= S_RUN;
        S_RUN:  if (!enable) state <= S_STOP;
        S_STOP: begin
          if (enable)     state <= S_RUN;
          else if (!busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (pop) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end

      // Capture lands behind the current contents; a pop shifts slot1 to the head.
      unique case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= fifo_rdata;
          else             slot1 <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            slot0 <= slot1;
            slot1 <= fifo_rdata;
          end else begin
            slot0 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)  word_count <= '0;
    else if (pop)  word_count <= word_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Randomized bench for fifo_drain_ctrl against a word-queue reference model.
module tb_fifo_drain_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned BL    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_read;
  logic [WIDTH-1:0] fifo_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0]      word_count;
`endif

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, and words popped from the FIFO not yet accepted downstream.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             rd_last;
  logic             run;
  int unsigned      beats;
  logic [15:0]      total_pops;
  logic [7:0]       next_word;

  int unsigned en_p, rdy_p, hold_p, rst_pm;
  logic        hold_empty;

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    rd_last    = 1'b0;
    run        = 1'b0;
    beats      = 0;
    total_pops = '0;
  endtask

  task automatic drive();
    reset_n    = !($urandom_range(999) < rst_pm);
    enable     = $urandom_range(99) < en_p;
    out_ready  = $urandom_range(99) < rdy_p;
    hold_empty = $urandom_range(99) < hold_p;
    fifo_empty = hold_empty || (fq.size() == 0);
  endtask

  task automatic load(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 8'd1;
    end
    fifo_empty = hold_empty || (fq.size() == 0);
  endtask

  task automatic cycle();
    int   outst;
    logic exp_valid;
    logic popped;
    logic exp_rd;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    outst     = exp_q.size();
    // A word read in the previous cycle is still in the RAM pipeline, not yet visible.
    exp_valid = (outst - int'(rd_last)) > 0;
    popped    = exp_valid && out_ready;
    exp_rd    = reset_n && run && !fifo_empty && ((outst - int'(popped)) < 2);
    check("fifo_read", 32'(fifo_read), 32'(exp_rd));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("busy",      32'(busy),      32'(outst > 0));
    check("out_last",  32'(out_last),  32'(exp_valid && ((beats % BL) == BL - 1)));
    if (exp_valid) check("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef FIFO_DRAIN_CNT_EN
    check("word_count", 32'(word_count), 32'(total_pops));
`endif
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
      fifo_rdata = WIDTH'($urandom);
    end else begin
      if (popped) begin
        void'(exp_q.pop_front());
        beats++;
        total_pops = total_pops + 16'd1;
      end
      if (exp_rd) begin
        w = fq.pop_front();
        exp_q.push_back(w);
        fifo_rdata = w;
      end else begin
        fifo_rdata = WIDTH'($urandom);
      end
      rd_last = exp_rd;
      run     = enable;
    end
    drive();
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    next_word  = 8'h10;
    hold_empty = 1'b0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    en_p = 0; rdy_p = 0; hold_p = 0; rst_pm = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fifo_read", 32'(fifo_read), 32'h0);
    @(posedge clk);
    #1;

    // Short transfer, then continuous stream with burst boundaries.
    en_p = 100; rdy_p = 100; hold_p = 0;
    drive();
    load(3);
    run_cycles(8);
    load(8);
    run_cycles(12);

    // Backpressure: buffer fills, reads stop, then release.
    rdy_p = 0;
    load(6);
    run_cycles(8);
    rdy_p = 100;
    run_cycles(10);

    // Disable while words are outstanding.
    rdy_p = 0;
    load(4);
    run_cycles(3);
    en_p = 0; rdy_p = 100;
    run_cycles(6);
    check("stop_idle_busy", 32'(busy), 32'h0);

    // Empty flag held: no reads.
    en_p = 100; hold_p = 100;
    run_cycles(6);

    // Reset with a full buffer discards it.
    hold_p = 0; rdy_p = 0;
    drive();
    load(2);
    run_cycles(4);
    reset_n = 1'b0;
    cycle();
    rdy_p = 100;
    load(4);
    run_cycles(10);

    // Randomized epochs.
    for (int unsigned e = 0; e < 20; e++) begin
      en_p   = $urandom_range(100, 30);
      rdy_p  = $urandom_range(100, 10);
      hold_p = $urandom_range(40);
      rst_pm = $urandom_range(15);
      for (int unsigned i = 0; i < 150; i++) begin
        if (fq.size() < 3) load($urandom_range(6));
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
